// File: rtl/mram_if_pkg.sv
// Shared constants and FSM encoding for the MRAM serial command interface.
package mram_if_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 16;

   localparam logic [2:0] SEL_IDLE  = 3'b000;
   localparam logic [2:0] SEL_WRITE = 3'b011;
   localparam logic [2:0] SEL_READ  = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_FLUSH,
      ST_CAPTURE,
      ST_DONE
   } tx_state_t;

endpackage

// File: rtl/mram_piso_shift.sv
// Loadable parallel-in/serial-out shifter, LSB first. The bit counter saturates
// once all W bits have been presented, which raises 'empty'.
module mram_piso_shift
   import mram_if_pkg::*;
#(
   parameter int W = ADDR_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift_en,
   input  logic [W-1:0] load_data,
   output logic         lsb,
   output logic         empty
);

   localparam int CNT_W = $clog2(W + 1);

   logic [W-1:0]     shreg;
   logic [CNT_W-1:0] bit_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shreg   <= load_data;
         bit_cnt <= '0;
      end else if (shift_en && !empty) begin
         shreg   <= shreg >> 1;
         bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   assign lsb   = shreg[0];
   assign empty = (bit_cnt == CNT_W'(W));

endmodule

// File: rtl/mram_serial_cmd_tx.sv
// Serialises one parallel MRAM command onto the serial address/data lines.
// Optional read-back capture is enabled by defining READBACK_CAPTURE_EN.
module mram_serial_cmd_tx
   import mram_if_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RST_CYCLES = 2,
   parameter int RD_LAT     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              mram_rst,
   output logic [2:0]        rw_sel,
   output logic              ser_addr,
   output logic              ser_wdata,
   input  logic              ser_rdata,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              done
);

`ifdef READBACK_CAPTURE_EN
   localparam bit CAPTURE_EN = 1'b1;
   logic [DATA_W-1:0] cap_sr;
`else
   localparam bit CAPTURE_EN = 1'b0;
   logic unused_rdata;
   assign unused_rdata = ser_rdata;
`endif

   tx_state_t         state;
   logic [4:0]        cnt;
   logic              cap_rd;
   logic [4:0]        flush_last;
   logic              load;
   logic              shift_en;
   logic [DATA_W-1:0] wdata_load;
   logic              addr_lsb;
   logic              addr_empty;
   logic              wdata_lsb;
   logic              wdata_empty;

   assign load       = (state == ST_IDLE) && cmd_valid && cmd_ready;
   assign shift_en   = (state == ST_SETUP) || ((state == ST_SHIFT) && !addr_empty);
   assign wdata_load = cmd_write ? cmd_wdata : '0;
   // Capturing reads wait RD_LAT cycles for the read-back; all others hold reset RST_CYCLES.
   assign flush_last = cap_rd ? 5'(RD_LAT - 1) : 5'(RST_CYCLES - 1);

   mram_piso_shift #(.W(ADDR_W)) u_addr_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .shift_en  (shift_en),
      .load_data (cmd_addr),
      .lsb       (addr_lsb),
      .empty     (addr_empty)
   );

   mram_piso_shift #(.W(DATA_W)) u_wdata_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .shift_en  (shift_en),
      .load_data (wdata_load),
      .lsb       (wdata_lsb),
      .empty     (wdata_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         cap_rd    <= 1'b0;
         cmd_ready <= 1'b1;
         mram_rst  <= 1'b1;
         rw_sel    <= SEL_IDLE;
         ser_addr  <= 1'b0;
         ser_wdata <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         done      <= 1'b0;
`ifdef READBACK_CAPTURE_EN
         cap_sr    <= '0;
`endif
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  state     <= ST_SETUP;
                  cmd_ready <= 1'b0;
                  mram_rst  <= 1'b0;
                  rw_sel    <= cmd_write ? SEL_WRITE : SEL_READ;
                  cap_rd    <= CAPTURE_EN && !cmd_write;
               end
            end
            ST_SETUP: begin
               state     <= ST_SHIFT;
               ser_addr  <= addr_lsb;
               ser_wdata <= wdata_lsb && !wdata_empty;
            end
            ST_SHIFT: begin
               if (addr_empty) begin
                  state     <= ST_FLUSH;
                  cnt       <= '0;
                  ser_addr  <= 1'b0;
                  ser_wdata <= 1'b0;
                  mram_rst  <= !cap_rd;
               end else begin
                  ser_addr  <= addr_lsb;
                  ser_wdata <= wdata_lsb && !wdata_empty;
               end
            end
            ST_FLUSH: begin
               if (cnt == flush_last) begin
                  cnt <= '0;
                  if (cap_rd) begin
                     state <= ST_CAPTURE;
                  end else begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     rw_sel   <= SEL_IDLE;
                     mram_rst <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
`ifdef READBACK_CAPTURE_EN
            ST_CAPTURE: begin
               cap_sr <= {ser_rdata, cap_sr[DATA_W-1:1]};
               if (cnt == 5'(DATA_W - 1)) begin
                  state    <= ST_DONE;
                  rd_data  <= {ser_rdata, cap_sr[DATA_W-1:1]};
                  rd_valid <= 1'b1;
                  done     <= 1'b1;
                  rw_sel   <= SEL_IDLE;
                  mram_rst <= 1'b1;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
`endif
            ST_DONE: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mram_serial_cmd_tx.sv
// Scoreboard bench for mram_serial_cmd_tx; expected per-cycle outputs are queued
// as each command is driven and compared on the falling clock edge.
module tb_mram_serial_cmd_tx;

   localparam int ADDR_W     = 20;
   localparam int DATA_W     = 16;
   localparam int RST_CYCLES = 2;
   localparam int RD_LAT     = 2;
`ifdef READBACK_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              mram_rst;
   logic [2:0]        rw_sel;
   logic              ser_addr;
   logic              ser_wdata;
   logic              ser_rdata;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              done;

   typedef struct {
      int          cmd;
      int          n;
      logic [2:0]  rw;
      logic        mrst;
      logic        sa;
      logic        sw;
      logic        dn;
      logic        rdy;
      logic        rdv;
      logic [15:0] rdd;
   } exp_t;

   exp_t        expQ[$];
   exp_t        mon;
   string       pfx;
   int          checks   = 0;
   int          failures = 0;
   int          cmdId    = 0;
   int          doneSeen = 0;
   logic [15:0] modelRd  = '0;

   mram_serial_cmd_tx #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RST_CYCLES (RST_CYCLES),
      .RD_LAT     (RD_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .mram_rst  (mram_rst),
      .rw_sel    (rw_sel),
      .ser_addr  (ser_addr),
      .ser_wdata (ser_wdata),
      .ser_rdata (ser_rdata),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Expected outputs for cycle n after acceptance (n = 1 is SETUP, n = L is done, L+1 idle).
   task automatic pushExpected(input logic w, input logic [19:0] a, input logic [15:0] d,
                               input logic [15:0] rword, input int n, input int L);
      exp_t e;
      bit   capRd;
      capRd  = CAP && !w;
      e.cmd  = cmdId;
      e.n    = n;
      e.rw   = w ? 3'b011 : 3'b010;
      e.mrst = 1'b0;
      e.sa   = 1'b0;
      e.sw   = 1'b0;
      e.dn   = 1'b0;
      e.rdy  = 1'b0;
      e.rdv  = 1'b0;
      e.rdd  = modelRd;
      if (n >= 2 && n <= ADDR_W + 1) begin
         e.sa = a[n-2];
         if (w && (n - 2) < DATA_W) e.sw = d[n-2];
      end else if (n > ADDR_W + 1 && n < L) begin
         e.mrst = !capRd;
      end else if (n == L) begin
         e.dn   = 1'b1;
         e.rw   = 3'b000;
         e.mrst = 1'b1;
         if (capRd) begin
            e.rdv   = 1'b1;
            modelRd = rword;
            e.rdd   = rword;
         end
      end else if (n == L + 1) begin
         e.rw   = 3'b000;
         e.mrst = 1'b1;
         e.rdy  = 1'b1;
      end
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic w, input logic [19:0] a, input logic [15:0] d,
                                input logic [15:0] rword, input bit keepValid, input int abortAt);
      int L;
      int base;
      L    = (w || !CAP) ? (2 + ADDR_W + RST_CYCLES) : (2 + ADDR_W + RD_LAT + DATA_W);
      base = ADDR_W + RD_LAT + 2;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmdId++;
      if (!keepValid) cmd_valid = 1'b0;
      for (int n = 1; n <= L + 1; n++) begin
         if (n > 1) begin
            @(posedge clk);
            #1;
         end
         if (n == abortAt) return;
         ser_rdata = (!w && n >= base && n < base + DATA_W) ? rword[n-base] : 1'b0;
         pushExpected(w, a, d, rword, n, L);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         mon = expQ.pop_front();
         pfx = $sformatf("cmd%0d.n%0d", mon.cmd, mon.n);
         checkOutput({pfx, ".cmd_ready"}, 32'(cmd_ready), 32'(mon.rdy));
         checkOutput({pfx, ".mram_rst"},  32'(mram_rst),  32'(mon.mrst));
         checkOutput({pfx, ".rw_sel"},    32'(rw_sel),    32'(mon.rw));
         checkOutput({pfx, ".ser_addr"},  32'(ser_addr),  32'(mon.sa));
         checkOutput({pfx, ".ser_wdata"}, 32'(ser_wdata), 32'(mon.sw));
         checkOutput({pfx, ".done"},      32'(done),      32'(mon.dn));
         checkOutput({pfx, ".rd_valid"},  32'(rd_valid),  32'(mon.rdv));
         checkOutput({pfx, ".rd_data"},   32'(rd_data),   32'(mon.rdd));
      end
   end

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
      checkOutput({tag, ".mram_rst"},  32'(mram_rst),  32'd1);
      checkOutput({tag, ".rw_sel"},    32'(rw_sel),    32'd0);
      checkOutput({tag, ".ser_addr"},  32'(ser_addr),  32'd0);
      checkOutput({tag, ".ser_wdata"}, 32'(ser_wdata), 32'd0);
      checkOutput({tag, ".done"},      32'(done),      32'd0);
      checkOutput({tag, ".rd_valid"},  32'(rd_valid),  32'd0);
      checkOutput({tag, ".rd_data"},   32'(rd_data),   32'd0);
   endtask

   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL watchdog expired got=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      ser_rdata = 1'b0;
      #12;
      checkResetValues("por");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] write addr 0x00000 data 0xAAAA");
      applyStimulus(1'b1, 20'h00000, 16'hAAAA, 16'h0000, 1'b0, 0);

      $display("[TB] read addr 0xABCDE");
      applyStimulus(1'b0, 20'hABCDE, 16'h5A5A, 16'h1234, 1'b0, 0);

      $display("[TB] back-to-back with cmd_valid held");
      applyStimulus(1'b1, 20'h12345, 16'hBEEF, 16'h0000, 1'b1, 0);
      applyStimulus(1'b1, 20'h6789A, 16'h1357, 16'h0000, 1'b0, 0);

      $display("[TB] cmd_valid raised during FLUSH");
      fork
         applyStimulus(1'b1, 20'hFFFFF, 16'hFFFF, 16'h0000, 1'b0, 0);
         begin
            @(posedge clk);
            repeat (ADDR_W + 1) @(posedge clk);
            #2;
            cmd_write = 1'b0;
            cmd_addr  = 20'h0F0F0;
            cmd_wdata = 16'h7777;
            cmd_valid = 1'b1;
         end
      join
      applyStimulus(1'b0, 20'h0F0F0, 16'h7777, 16'hC3A5, 1'b0, 0);

      $display("[TB] reset during SHIFT bit 7");
      applyStimulus(1'b1, 20'h5A5A5, 16'h00FF, 16'h0000, 1'b0, 9);
      #1;
      rst = 1'b0;
      #1;
      checkResetValues("midrst");
      modelRd = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen++;
      end
      checkOutput("no_done_after_abort", 32'(doneSeen), 32'd0);

      $display("[TB] write after abort");
      applyStimulus(1'b1, 20'h00F0F, 16'h8001, 16'h0000, 1'b0, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
